// File: rtl/data_bus_responder.sv
// CPU data-port responder: word-addressed RAM plus a peripheral page with
// LED output, synchronised switches and a prescaled compare timer.
module data_bus_responder #(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr_i,
  input  logic             memwr_i,
  input  logic [31:0]      wr_data_i,
  output logic [31:0]      rd_data_o,
  input  logic [SW_W-1:0]  sw_i,
  output logic [LED_W-1:0] led_o,
  output logic             irq_o
);

  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH) << 2;

  // Word offsets (byte offset >> 2) inside the peripheral page
  localparam logic [9:0] OFS_LED    = 10'h000;
  localparam logic [9:0] OFS_SW     = 10'h001;
  localparam logic [9:0] OFS_TCTRL  = 10'h004;
  localparam logic [9:0] OFS_TPRESC = 10'h005;
  localparam logic [9:0] OFS_TCOUNT = 10'h006;
  localparam logic [9:0] OFS_TCMP   = 10'h007;
  localparam logic [9:0] OFS_TSTAT  = 10'h008;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_AR  = 1;
  localparam int unsigned CTRL_IEN = 2;

  logic [31:0] mem_q [RAM_DEPTH];

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [2:0]       tctrl_q, tctrl_d;
  logic [31:0]      tpresc_q, tpresc_d;
  logic [31:0]      presc_cnt_q, presc_cnt_d;
  logic [31:0]      tcount_q, tcount_d;
  logic [31:0]      tcmp_q, tcmp_d;
  logic             match_q, match_d;
  logic             irq_q, irq_d;

  logic              ram_hit_c, mmio_hit_c, wr_en_c, ram_we_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic [9:0]        wofs_c;
  logic              wr_led_c, wr_tctrl_c, wr_tpresc_c, wr_tcount_c, wr_tcmp_c, wr_tstat_c;
  logic              tick_c, cmp_hit_c;
  logic [31:0]       next_cnt_c;
  logic [1:0]        unused_addr_lsb;

  assign unused_addr_lsb = addr_i[1:0];

  // Address decode and per-register write strobes; writes are blocked during reset
  always_comb begin
    ram_hit_c   = 33'(addr_i) < RAM_BYTES;
    mmio_hit_c  = addr_i[31:12] == MMIO_BASE[31:12];
    ram_idx_c   = addr_i[RAM_AW+1:2];
    wofs_c      = addr_i[11:2];
    wr_en_c     = memwr_i & ~rst;
    ram_we_c    = wr_en_c & ram_hit_c;
    wr_led_c    = wr_en_c & mmio_hit_c & (wofs_c == OFS_LED);
    wr_tctrl_c  = wr_en_c & mmio_hit_c & (wofs_c == OFS_TCTRL);
    wr_tpresc_c = wr_en_c & mmio_hit_c & (wofs_c == OFS_TPRESC);
    wr_tcount_c = wr_en_c & mmio_hit_c & (wofs_c == OFS_TCOUNT);
    wr_tcmp_c   = wr_en_c & mmio_hit_c & (wofs_c == OFS_TCMP);
    wr_tstat_c  = wr_en_c & mmio_hit_c & (wofs_c == OFS_TSTAT);
  end

  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      mem_q[ram_idx_c] <= wr_data_i;
    end
  end

  // Timer: prescaler, counter, compare; CPU writes take priority over tick updates
  always_comb begin
    tick_c     = tctrl_q[CTRL_EN] & (presc_cnt_q == tpresc_q);
    next_cnt_c = tcount_q + 32'd1;
    cmp_hit_c  = tick_c & (next_cnt_c == tcmp_q);

    led_d       = wr_led_c    ? wr_data_i[LED_W-1:0] : led_q;
    tctrl_d     = wr_tctrl_c  ? wr_data_i[2:0]       : tctrl_q;
    tpresc_d    = wr_tpresc_c ? wr_data_i            : tpresc_q;
    tcmp_d      = wr_tcmp_c   ? wr_data_i            : tcmp_q;
    presc_cnt_d = presc_cnt_q;
    tcount_d    = tcount_q;
    match_d     = match_q;

    if (wr_tpresc_c) begin
      presc_cnt_d = '0;
    end else if (tctrl_q[CTRL_EN]) begin
      presc_cnt_d = tick_c ? 32'd0 : presc_cnt_q + 32'd1;
    end

    if (wr_tcount_c) begin
      tcount_d = wr_data_i;
    end else if (tick_c) begin
      tcount_d = (cmp_hit_c && tctrl_q[CTRL_AR]) ? 32'd0 : next_cnt_c;
    end

    if (cmp_hit_c) begin
      match_d = 1'b1;
    end else if (wr_tstat_c && wr_data_i[0]) begin
      match_d = 1'b0;
    end

    irq_d = match_d & tctrl_d[CTRL_IEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      tctrl_q     <= '0;
      tpresc_q    <= '0;
      presc_cnt_q <= '0;
      tcount_q    <= '0;
      tcmp_q      <= 32'hFFFF_FFFF;
      match_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      led_q       <= led_d;
      sw_meta_q   <= sw_i;
      sw_sync_q   <= sw_meta_q;
      tctrl_q     <= tctrl_d;
      tpresc_q    <= tpresc_d;
      presc_cnt_q <= presc_cnt_d;
      tcount_q    <= tcount_d;
      tcmp_q      <= tcmp_d;
      match_q     <= match_d;
      irq_q       <= irq_d;
    end
  end

  // Read mux: same-cycle response from current state
  always_comb begin
    rd_data_o = '0;
    if (ram_hit_c) begin
      rd_data_o = mem_q[ram_idx_c];
    end else if (mmio_hit_c) begin
      case (wofs_c)
        OFS_LED:    rd_data_o = 32'(led_q);
        OFS_SW:     rd_data_o = 32'(sw_sync_q);
        OFS_TCTRL:  rd_data_o = 32'(tctrl_q);
        OFS_TPRESC: rd_data_o = tpresc_q;
        OFS_TCOUNT: rd_data_o = tcount_q;
        OFS_TCMP:   rd_data_o = tcmp_q;
        OFS_TSTAT:  rd_data_o = 32'(match_q);
        default:    rd_data_o = '0;
      endcase
    end
  end

  assign led_o = led_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder with a queue-based scoreboard.
module tb_data_bus_responder;

  localparam logic [31:0] A_LED    = 32'hFFFF_F000;
  localparam logic [31:0] A_SW     = 32'hFFFF_F004;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF_F010;
  localparam logic [31:0] A_TPRESC = 32'hFFFF_F014;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_F018;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_F01C;
  localparam logic [31:0] A_TSTAT  = 32'hFFFF_F020;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic        memwr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        irq_o;

  logic [31:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  data_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .memwr_i   (memwr_i),
    .wr_data_i (wr_data_i),
    .rd_data_o (rd_data_o),
    .sw_i      (sw_i),
    .led_o     (led_o),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i    = a;
    wr_data_i = d;
    memwr_i   = 1'b1;
    cyc(1);
    memwr_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    addr_i  = a;
    memwr_i = 1'b0;
    exp_q.push_back(e);
    #1;
    chk(tag, rd_data_o);
  endtask

  task automatic ex_led(input logic [15:0] e, input string tag);
    exp_q.push_back(32'(e));
    chk(tag, 32'(led_o));
  endtask

  task automatic ex_irq(input logic e, input string tag);
    exp_q.push_back(32'(e));
    chk(tag, 32'(irq_o));
  endtask

  initial begin
    rst = 1'b1; addr_i = '0; memwr_i = 1'b0; wr_data_i = '0; sw_i = '0;
    cyc(2);
    rst = 1'b0;
    ex_led(16'h0, "rst_led");
    ex_irq(1'b0, "rst_irq");
    rd(A_TCMP,   32'hFFFF_FFFF, "rst_tcmp");
    rd(A_TCOUNT, 32'h0, "rst_tcount");
    rd(A_TCTRL,  32'h0, "rst_tctrl");

    // RAM word access and decode boundaries
    wr(32'h0000_0014, 32'h1234_5678);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd10");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_rd13");
    rd(32'h0000_0014, 32'h1234_5678, "ram_rd14");
    rd(32'h0000_1000, 32'h0, "ram_past_end");
    wr(32'h8000_0000, 32'h5555_AAAA);
    rd(32'h8000_0000, 32'h0, "unmapped");
    wr(32'hFFFF_F008, 32'h5555_AAAA);
    rd(32'hFFFF_F008, 32'h0, "mmio_hole");

    // Same-cycle read during a write returns the old word
    addr_i = 32'h0000_0010; wr_data_i = 32'hCAFE_F00D; memwr_i = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("raw_old", rd_data_o);
    cyc(1);
    memwr_i = 1'b0;
    rd(32'h0000_0010, 32'hCAFE_F00D, "raw_new");

    // LED and switch synchroniser
    wr(A_LED, 32'h0001_A5A5);
    ex_led(16'hA5A5, "led_out");
    rd(A_LED, 32'h0000_A5A5, "led_rd");
    sw_i = 16'h00F0;
    rd(A_SW, 32'h0, "sw_c0");
    cyc(1);
    rd(A_SW, 32'h0, "sw_c1");
    cyc(1);
    rd(A_SW, 32'h0000_00F0, "sw_c2");
    wr(A_SW, 32'hFFFF_FFFF);
    rd(A_SW, 32'h0000_00F0, "sw_ro");

    // Free-running timer: TPRESC=3 -> one increment every 4 cycles
    wr(A_TPRESC, 32'd3);
    wr(A_TCMP, 32'd5);
    wr(A_TCTRL, 32'h5);
    cyc(3);
    rd(A_TCOUNT, 32'd0, "fr_w3");
    cyc(1);
    rd(A_TCOUNT, 32'd1, "fr_w4");
    cyc(4);
    rd(A_TCOUNT, 32'd2, "fr_w8");
    cyc(11);
    rd(A_TCOUNT, 32'd4, "fr_w19");
    ex_irq(1'b0, "fr_irq_pre");
    cyc(1);
    rd(A_TCOUNT, 32'd5, "fr_w20");
    rd(A_TSTAT, 32'd1, "fr_match");
    ex_irq(1'b1, "fr_irq");
    wr(A_TSTAT, 32'd0);
    rd(A_TSTAT, 32'd1, "fr_wr0");
    cyc(3);
    rd(A_TCOUNT, 32'd6, "fr_w24");
    ex_irq(1'b1, "fr_irq_hold");
    wr(A_TCTRL, 32'hFFFF_FFF8);
    rd(A_TCTRL, 32'h0, "tctrl_mask");
    ex_irq(1'b0, "irq_en_off");
    rd(A_TSTAT, 32'd1, "match_sticky");
    wr(A_TSTAT, 32'd1);
    rd(A_TSTAT, 32'd0, "w1c");

    // Autoreload with TPRESC=0, TCMP=2
    wr(A_TCOUNT, 32'd0);
    wr(A_TPRESC, 32'd0);
    wr(A_TCMP, 32'd2);
    wr(A_TCTRL, 32'h7);
    rd(A_TCOUNT, 32'd0, "ar_a0");
    cyc(1);
    rd(A_TCOUNT, 32'd1, "ar_a1");
    cyc(1);
    rd(A_TCOUNT, 32'd0, "ar_a2");
    rd(A_TSTAT, 32'd1, "ar_match");
    ex_irq(1'b1, "ar_irq");
    wr(A_TSTAT, 32'd1);
    ex_irq(1'b0, "ar_clr_irq");
    rd(A_TSTAT, 32'd0, "ar_clr");
    rd(A_TCOUNT, 32'd1, "ar_a3");
    wr(A_TSTAT, 32'd1);
    rd(A_TSTAT, 32'd1, "ar_set_wins");
    ex_irq(1'b1, "ar_set_irq");
    rd(A_TCOUNT, 32'd0, "ar_a4");

    // TCOUNT write in a tick cycle beats the increment
    wr(A_TCOUNT, 32'd100);
    rd(A_TCOUNT, 32'd100, "coll_wr");
    cyc(1);
    rd(A_TCOUNT, 32'd101, "coll_next");

    // Wrap from all-ones with no match
    wr(A_TCTRL, 32'h0);
    wr(A_TSTAT, 32'd1);
    wr(A_TCMP, 32'd7);
    wr(A_TCOUNT, 32'hFFFF_FFFF);
    rd(A_TCOUNT, 32'hFFFF_FFFF, "wrap_pre");
    rd(A_TSTAT, 32'd0, "wrap_stat0");
    wr(A_TCTRL, 32'h5);
    cyc(1);
    rd(A_TCOUNT, 32'd0, "wrap_zero");
    rd(A_TSTAT, 32'd0, "wrap_nomatch");
    ex_irq(1'b0, "wrap_irq");
    cyc(6);
    rd(A_TCOUNT, 32'd6, "run_e7");
    ex_irq(1'b0, "run_irq0");
    cyc(1);
    rd(A_TSTAT, 32'd1, "run_match");
    ex_irq(1'b1, "run_irq1");

    // Reset mid-run; writes during reset are ignored, RAM is kept
    rst = 1'b1;
    addr_i = 32'h0000_0014; wr_data_i = 32'h0; memwr_i = 1'b1;
    cyc(1);
    addr_i = A_LED; wr_data_i = 32'h0000_FFFF;
    cyc(1);
    rst = 1'b0; memwr_i = 1'b0;
    ex_irq(1'b0, "mr_irq");
    ex_led(16'h0, "mr_led");
    rd(A_TCOUNT, 32'd0, "mr_tcount");
    rd(A_TCTRL, 32'd0, "mr_tctrl");
    rd(A_TCMP, 32'hFFFF_FFFF, "mr_tcmp");
    rd(A_TSTAT, 32'd0, "mr_tstat");
    rd(32'h0000_0010, 32'hCAFE_F00D, "mr_ram10");
    rd(32'h0000_0014, 32'h1234_5678, "mr_ram14");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
